// File: rtl/cpe_data_mem_if.sv
// Request/response bundle for the cpe_data_mem byte-addressed data memory.
// Handshake: a request (exactly one of mem_rd_w_i_h / mem_wr_w_i_h) is taken
// on any rising edge where mem_busy_w_o_h is low and reset is low; while
// busy is high requests are silently dropped, so the master must hold them.
// Read data is qualified by a single-cycle mem_rd_valid_w_o_h pulse and
// rejected requests by a single-cycle mem_err_w_o_h pulse.
interface cpe_data_mem_if;
    logic [31:0] mem_addr_w_i;
    logic [31:0] mem_data_w_i;
    logic        mem_wr_w_i_h;
    logic        mem_rd_w_i_h;
    logic [1:0]  mem_wr_byte_sel_w_i;
    logic [1:0]  mem_rd_byte_sel_w_i;
    logic        mem_rd_signed_w_i_h;
    logic [31:0] mem_data_w_o;
    logic        mem_rd_valid_w_o_h;
    logic        mem_busy_w_o_h;
    logic        mem_err_w_o_h;

    modport master (
        output mem_addr_w_i, mem_data_w_i, mem_wr_w_i_h, mem_rd_w_i_h,
               mem_wr_byte_sel_w_i, mem_rd_byte_sel_w_i, mem_rd_signed_w_i_h,
        input  mem_data_w_o, mem_rd_valid_w_o_h, mem_busy_w_o_h, mem_err_w_o_h
    );

    modport slave (
        input  mem_addr_w_i, mem_data_w_i, mem_wr_w_i_h, mem_rd_w_i_h,
               mem_wr_byte_sel_w_i, mem_rd_byte_sel_w_i, mem_rd_signed_w_i_h,
        output mem_data_w_o, mem_rd_valid_w_o_h, mem_busy_w_o_h, mem_err_w_o_h
    );
endinterface

// File: rtl/cpe_data_mem.sv
// Byte-addressed data memory with byte/half/word access, configurable byte
// order and a fixed read latency of RD_LATENCY clocks. Writes commit at the
// accepting edge; reads snapshot storage at the accepting edge and deliver
// the formatted value through an IDLE -> WAIT -> RESP sequence.
module cpe_data_mem #(
    parameter int ADDR_BITS  = 16,
    parameter int RD_LATENCY = 1,
    parameter int BIG_ENDIAN = 1
) (
    input  logic         clk_w_i,
    input  logic         res_w_i_h,
    cpe_data_mem_if.slave bus,
    output logic [1:0]   fsm_state
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

    logic [7:0]  mem [DEPTH];
    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] hold;
    logic [31:0] data_q;
    logic        valid_q;
    logic        err_q;

    logic        busy;
    logic        req_any;
    logic        both;
    logic [1:0]  size;
    logic        align_ok;
    logic        range_ok;
    logic        bad;
    logic        do_wr;
    logic        do_rd;
    logic [ADDR_BITS-1:0] a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] half;
    logic [31:0] rd_fmt;

    // Request qualification: legality of the single access being asked for.
    always_comb begin
        busy     = (state == ST_WAIT);
        req_any  = (bus.mem_rd_w_i_h || bus.mem_wr_w_i_h) && !busy;
        both     = bus.mem_rd_w_i_h && bus.mem_wr_w_i_h;
        size     = bus.mem_rd_w_i_h ? bus.mem_rd_byte_sel_w_i : bus.mem_wr_byte_sel_w_i;
        range_ok = (bus.mem_addr_w_i >> ADDR_BITS) == 32'd0;
        case (size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = !bus.mem_addr_w_i[0];
            2'b10:   align_ok = (bus.mem_addr_w_i[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        bad   = both || !align_ok || !range_ok;
        do_wr = req_any && bus.mem_wr_w_i_h && !bad;
        do_rd = req_any && bus.mem_rd_w_i_h && !bad;
    end

    // Storage snapshot and read formatting (byte order, extension).
    always_comb begin
        a0   = bus.mem_addr_w_i[ADDR_BITS-1:0];
        a1   = a0 + ADDR_BITS'(1);
        a2   = a0 + ADDR_BITS'(2);
        a3   = a0 + ADDR_BITS'(3);
        b0   = mem[a0];
        b1   = mem[a1];
        b2   = mem[a2];
        b3   = mem[a3];
        half = (BIG_ENDIAN != 0) ? {b0, b1} : {b1, b0};
        case (bus.mem_rd_byte_sel_w_i)
            2'b00:   rd_fmt = {{24{bus.mem_rd_signed_w_i_h & b0[7]}}, b0};
            2'b01:   rd_fmt = {{16{bus.mem_rd_signed_w_i_h & half[15]}}, half};
            2'b10:   rd_fmt = (BIG_ENDIAN != 0) ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
            default: rd_fmt = 32'd0;
        endcase
    end

    // Write commit; storage is never reset and a write during reset is dropped.
    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_h && do_wr) begin
            case (bus.mem_wr_byte_sel_w_i)
                2'b00: mem[a0] <= bus.mem_data_w_i[7:0];
                2'b01: begin
                    if (BIG_ENDIAN != 0) begin
                        mem[a0] <= bus.mem_data_w_i[15:8];
                        mem[a1] <= bus.mem_data_w_i[7:0];
                    end else begin
                        mem[a0] <= bus.mem_data_w_i[7:0];
                        mem[a1] <= bus.mem_data_w_i[15:8];
                    end
                end
                2'b10: begin
                    if (BIG_ENDIAN != 0) begin
                        mem[a0] <= bus.mem_data_w_i[31:24];
                        mem[a1] <= bus.mem_data_w_i[23:16];
                        mem[a2] <= bus.mem_data_w_i[15:8];
                        mem[a3] <= bus.mem_data_w_i[7:0];
                    end else begin
                        mem[a0] <= bus.mem_data_w_i[7:0];
                        mem[a1] <= bus.mem_data_w_i[15:8];
                        mem[a2] <= bus.mem_data_w_i[23:16];
                        mem[a3] <= bus.mem_data_w_i[31:24];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read sequencer plus registered valid/error/data outputs.
    always_ff @(posedge clk_w_i) begin
        if (res_w_i_h) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            hold    <= 32'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= req_any && bad;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (do_rd) begin
                        if (RD_LATENCY == 1) begin
                            state   <= ST_RESP;
                            valid_q <= 1'b1;
                            data_q  <= rd_fmt;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 3'd1;
                            hold  <= rd_fmt;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state   <= ST_RESP;
                        valid_q <= 1'b1;
                        data_q  <= hold;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_data_w_o       = data_q;
    assign bus.mem_rd_valid_w_o_h = valid_q;
    assign bus.mem_busy_w_o_h     = busy;
    assign bus.mem_err_w_o_h      = err_q;
    assign fsm_state              = state;
endmodule
